sc_timer_transition: RTL and testbench

Parametrised transition timer: the successor to the fixed 27-bit all-ones end-of-count counter used for screen and level transitions. Terminal count, tick prescaler and mode (one-shot or periodic) are runtime inputs. The block adds start, pause and clear control, and reports progress through an active-low end-of-count pulse plus busy and done levels. It sits between the game-control FSM and the transition and animation sequencers, on the 50 MHz domain.

---
 rtl/sc_timer_pkg.sv | 15 +
 rtl/sc_prescaler_tick.sv | 28 ++
 rtl/sc_timer_transition.sv | 119 +++++++++++
 tb/tb_sc_timer_transition.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_timer_pkg.sv
// Shared types and defaults for the transition timer.
// State encoding is fixed so it can be probed by external tools.
package sc_timer_pkg;

  localparam int TIMER_DW_DEF   = 27;
  localparam int PRESCALE_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sc_prescaler_tick.sv
// Reload counter: tick every reload+1 enabled clocks.
// Holds its value while disabled, so pauses neither lose nor add ticks.
module sc_prescaler_tick #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] reload,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;

  assign tick = enable && (cnt == reload);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sc_timer_transition.sv
// Transition timer: runtime terminal/prescale/mode, start/pause/clear,
// active-low end-of-count pulse plus busy and done levels.
module sc_timer_transition
  import sc_timer_pkg::*;
#(
  parameter int TIMER_DATAWIDTH_BUS = TIMER_DW_DEF,
  parameter int PRESCALE_WIDTH      = PRESCALE_W_DEF
) (
  input  logic                           SC_TIMER_CLOCK_50,
  input  logic                           SC_TIMER_RESET_InLow,
  input  logic                           SC_TIMER_start_InLow,
  input  logic                           SC_TIMER_clear_InLow,
  input  logic                           SC_TIMER_pause_InLow,
  input  logic                           SC_TIMER_periodic_In,
  input  logic [TIMER_DATAWIDTH_BUS-1:0] SC_TIMER_terminal_In,
  input  logic [PRESCALE_WIDTH-1:0]      SC_TIMER_prescale_In,
  output logic                           SC_TIMER_eoc_OutLow,
  output logic                           SC_TIMER_busy_OutLow,
  output logic                           SC_TIMER_done_OutLow,
  output logic [TIMER_DATAWIDTH_BUS-1:0] SC_TIMER_count_Out
);

  state_t state, state_nxt;

  logic                           start_prev;
  logic                           start_req;
  logic                           clr;
  logic                           active;
  logic                           tick;
  logic                           at_term;
  logic                           cap_per;
  logic [TIMER_DATAWIDTH_BUS-1:0] cap_term;
  logic [PRESCALE_WIDTH-1:0]      cap_pre;
  logic [TIMER_DATAWIDTH_BUS-1:0] count;
  logic                           eoc_q;

  assign clr       = !SC_TIMER_clear_InLow;
  assign start_req = !SC_TIMER_start_InLow && start_prev;
  assign at_term   = (count == cap_term);

  // PAUSE with pause released counts on that same edge, so a pause
  // of N cycles costs exactly N cycles.
  assign active = !clr && !start_req && SC_TIMER_pause_InLow &&
                  (state == RUN || state == PAUSE);

  sc_prescaler_tick #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk    (SC_TIMER_CLOCK_50),
    .rst_n  (SC_TIMER_RESET_InLow),
    .clear  (clr || start_req),
    .enable (active),
    .reload (cap_pre),
    .tick   (tick)
  );

  always_ff @(posedge SC_TIMER_CLOCK_50 or negedge SC_TIMER_RESET_InLow) begin
    if (!SC_TIMER_RESET_InLow) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (start_req) begin
      state_nxt = RUN;
    end else if (state == RUN || state == PAUSE) begin
      if (!SC_TIMER_pause_InLow) begin
        state_nxt = PAUSE;
      end else if (tick && at_term && !cap_per) begin
        state_nxt = DONE;
      end else begin
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge SC_TIMER_CLOCK_50 or negedge SC_TIMER_RESET_InLow) begin
    if (!SC_TIMER_RESET_InLow) begin
      start_prev <= 1'b1;
      cap_per    <= 1'b0;
      cap_term   <= '0;
      cap_pre    <= '0;
      count      <= '0;
      eoc_q      <= 1'b1;
    end else begin
      start_prev <= SC_TIMER_start_InLow;
      if (clr) begin
        count <= '0;
        eoc_q <= 1'b1;
      end else if (start_req) begin
        cap_per  <= SC_TIMER_periodic_In;
        cap_term <= SC_TIMER_terminal_In;
        cap_pre  <= SC_TIMER_prescale_In;
        count    <= '0;
        eoc_q    <= 1'b1;
      end else begin
        eoc_q <= !(tick && at_term);
        if (tick) begin
          if (!at_term) begin
            count <= count + 1'b1;
          end else if (cap_per) begin
            count <= '0;
          end
        end
      end
    end
  end

  assign SC_TIMER_eoc_OutLow  = eoc_q;
  assign SC_TIMER_busy_OutLow = !(state == RUN || state == PAUSE);
  assign SC_TIMER_done_OutLow = !(state == DONE);
  assign SC_TIMER_count_Out   = count;

endmodule

// File: tb/tb_sc_timer_transition.sv
// Bench for sc_timer_transition: directed scenarios plus random
// stimulus against an elapsed-clock arithmetic model.
module tb_sc_timer_transition;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b1;
  logic        clear = 1'b1;
  logic        pause = 1'b1;
  logic        per = 1'b0;
  logic [26:0] term = '0;
  logic [7:0]  pre = '0;
  logic [3:0]  term4 = 4'hF;

  logic        eoc, busy, done;
  logic [26:0] count;
  logic        eoc4, busy4, done4;
  logic [3:0]  count4;
  logic [29:0] obs;

  int n_checks = 0;
  int n_pass = 0;

  bit     m_sprev, m_run, m_done, m_per, m_eoc;
  longint m_act, m_T, m_P;

  always #10 clk = ~clk;

  assign obs = {eoc, busy, done, count};

  sc_timer_transition dut (
    .SC_TIMER_CLOCK_50    (clk),
    .SC_TIMER_RESET_InLow (rst_n),
    .SC_TIMER_start_InLow (start),
    .SC_TIMER_clear_InLow (clear),
    .SC_TIMER_pause_InLow (pause),
    .SC_TIMER_periodic_In (per),
    .SC_TIMER_terminal_In (term),
    .SC_TIMER_prescale_In (pre),
    .SC_TIMER_eoc_OutLow  (eoc),
    .SC_TIMER_busy_OutLow (busy),
    .SC_TIMER_done_OutLow (done),
    .SC_TIMER_count_Out   (count)
  );

  sc_timer_transition #(
    .TIMER_DATAWIDTH_BUS(4)
  ) dut4 (
    .SC_TIMER_CLOCK_50    (clk),
    .SC_TIMER_RESET_InLow (rst_n),
    .SC_TIMER_start_InLow (start),
    .SC_TIMER_clear_InLow (clear),
    .SC_TIMER_pause_InLow (pause),
    .SC_TIMER_periodic_In (per),
    .SC_TIMER_terminal_In (term4),
    .SC_TIMER_prescale_In (pre),
    .SC_TIMER_eoc_OutLow  (eoc4),
    .SC_TIMER_busy_OutLow (busy4),
    .SC_TIMER_done_OutLow (done4),
    .SC_TIMER_count_Out   (count4)
  );

  task automatic model_reset();
    m_sprev = 1; m_run = 0; m_done = 0; m_per = 0; m_eoc = 1;
    m_act = 0; m_T = 0; m_P = 0;
  endtask

  // Expected {eoc, busy, done, count} from elapsed counting clocks.
  function automatic logic [29:0] exp_word();
    longint c;
    if (m_done) c = m_T;
    else if (!m_run) c = 0;
    else if (m_per) c = (m_act / (m_P + 1)) % (m_T + 1);
    else c = m_act / (m_P + 1);
    return {m_eoc, !m_run, !m_done, c[26:0]};
  endfunction

  task automatic step();
    bit req;
    @(posedge clk);
    req = !start && m_sprev;
    m_sprev = start;
    if (!clear) begin
      m_run = 0; m_done = 0; m_act = 0; m_eoc = 1;
    end else if (req) begin
      m_T = term; m_P = pre; m_per = per;
      m_run = 1; m_done = 0; m_act = 0; m_eoc = 1;
    end else if (m_run && pause) begin
      m_act++;
      if (m_act % ((m_T + 1) * (m_P + 1)) == 0) begin
        m_eoc = 0;
        if (!m_per) begin m_run = 0; m_done = 1; end
      end else begin
        m_eoc = 1;
      end
    end else begin
      m_eoc = 1;
    end
    #1;
  endtask

  task automatic pulse_start();
    start = 0;
    step();
    start = 1;
  endtask

  task automatic test_reset();
    model_reset();
    #25;
    n_checks++;
    if (obs !== {3'b111, 27'd0})
      $display("FAIL reset got=%h exp=%h", obs, {3'b111, 27'd0});
    else n_pass++;
    #3 rst_n = 1;
    for (int j = 0; j < 3; j++) begin
      step();
      n_checks++;
      if (obs !== exp_word()) $display("FAIL reset_idle got=%h exp=%h", obs, exp_word());
      else n_pass++;
    end
  endtask

  task automatic test_oneshot();
    term = 3; pre = 0; per = 0;
    pulse_start();
    n_checks++;
    if ({busy, count} !== {1'b0, 27'd0})
      $display("FAIL oneshot_start got=%h exp=%h", {busy, count}, {1'b0, 27'd0});
    else n_pass++;
    for (int j = 1; j <= 8; j++) begin
      step();
      n_checks++;
      if (eoc !== (j == 4 ? 1'b0 : 1'b1) || obs !== exp_word())
        $display("FAIL oneshot j=%0d got=%h exp=%h", j, obs, exp_word());
      else n_pass++;
    end
    n_checks++;
    if ({done, busy, count} !== {1'b0, 1'b1, 27'd3})
      $display("FAIL oneshot_hold got=%h exp=%h", {done, busy, count}, {1'b0, 1'b1, 27'd3});
    else n_pass++;
  endtask

  task automatic test_periodic();
    int last = 0;
    int pulses = 0;
    term = 2; pre = 1; per = 1;
    pulse_start();
    for (int j = 1; j <= 31; j++) begin
      step();
      n_checks++;
      if (obs !== exp_word()) $display("FAIL periodic j=%0d got=%h exp=%h", j, obs, exp_word());
      else n_pass++;
      if (!eoc) begin
        n_checks++;
        if (j - last != 6) $display("FAIL periodic_gap got=%0d exp=6", j - last);
        else n_pass++;
        last = j;
        pulses++;
      end
    end
    n_checks++;
    if (pulses != 5) $display("FAIL periodic_pulses got=%0d exp=5", pulses);
    else n_pass++;
    clear = 0; step(); clear = 1;
  endtask

  task automatic test_pause();
    int eoc_at = -1;
    term = 9; pre = 0; per = 0;
    pulse_start();
    for (int j = 1; j <= 25; j++) begin
      pause = !(j >= 5 && j <= 11);
      step();
      n_checks++;
      if (obs !== exp_word() || (!pause && count !== 27'd4))
        $display("FAIL pause j=%0d got=%h exp=%h", j, obs, exp_word());
      else n_pass++;
      if (!eoc) eoc_at = j;
    end
    pause = 1;
    n_checks++;
    if (eoc_at != 17) $display("FAIL pause_eoc got=%0d exp=17", eoc_at);
    else n_pass++;
  endtask

  task automatic test_clear_start();
    term = 9; pre = 0;
    pulse_start();
    step(); step();
    clear = 0; start = 0;
    step();
    clear = 1;
    n_checks++;
    if ({eoc, busy, count} !== {2'b11, 27'd0} || obs !== exp_word())
      $display("FAIL clear_start got=%h exp=%h", obs, {2'b11, 27'd0});
    else n_pass++;
    for (int j = 0; j < 5; j++) begin
      step();
      n_checks++;
      if (busy !== 1'b1 || obs !== exp_word())
        $display("FAIL no_retrigger j=%0d got=%h exp=%h", j, obs, exp_word());
      else n_pass++;
    end
    start = 1;
    step();
  endtask

  task automatic test_restart();
    int eoc_at = -1;
    term = 9; pre = 0; per = 0;
    pulse_start();
    for (int j = 0; j < 5; j++) step();
    n_checks++;
    if (count !== 27'd5) $display("FAIL restart_pre got=%0d exp=5", count);
    else n_pass++;
    pulse_start();
    n_checks++;
    if ({busy, count} !== {1'b0, 27'd0})
      $display("FAIL restart got=%h exp=%h", {busy, count}, {1'b0, 27'd0});
    else n_pass++;
    for (int j = 1; j <= 12; j++) begin
      step();
      n_checks++;
      if (obs !== exp_word()) $display("FAIL restart j=%0d got=%h exp=%h", j, obs, exp_word());
      else n_pass++;
      if (!eoc) eoc_at = j;
    end
    n_checks++;
    if (eoc_at != 10) $display("FAIL restart_eoc got=%0d exp=10", eoc_at);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    term = 9; pre = 0; per = 1;
    pulse_start();
    for (int j = 0; j < 3; j++) step();
    #3 rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== {3'b111, 27'd0})
      $display("FAIL async_reset got=%h exp=%h", obs, {3'b111, 27'd0});
    else n_pass++;
    #7 rst_n = 1;
    for (int j = 0; j < 3; j++) begin
      step();
      n_checks++;
      if (obs !== exp_word()) $display("FAIL post_reset got=%h exp=%h", obs, exp_word());
      else n_pass++;
    end
  endtask

  task automatic test_all_ones();
    term4 = 4'hF; pre = 0; per = 0;
    pulse_start();
    for (int j = 1; j <= 20; j++) begin
      step();
      n_checks++;
      if (eoc4 !== (j == 16 ? 1'b0 : 1'b1))
        $display("FAIL all_ones j=%0d got=%b exp=%b", j, eoc4, (j == 16 ? 1'b0 : 1'b1));
      else n_pass++;
    end
    n_checks++;
    if ({done4, busy4, count4} !== {2'b01, 4'hF})
      $display("FAIL all_ones_hold got=%h exp=%h", {done4, busy4, count4}, {2'b01, 4'hF});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int j = 0; j < 800; j++) begin
      start = ($urandom_range(0, 24) != 0);
      clear = ($urandom_range(0, 59) != 0);
      pause = ($urandom_range(0, 5) != 0);
      per   = 1'($urandom_range(0, 1));
      term  = 27'($urandom_range(0, 6));
      pre   = 8'($urandom_range(0, 3));
      step();
      n_checks++;
      if (obs !== exp_word()) $display("FAIL random j=%0d got=%h exp=%h", j, obs, exp_word());
      else n_pass++;
    end
    start = 1; clear = 1; pause = 1;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_clear_start();
    test_restart();
    test_async_reset();
    test_all_ones();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
